hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and stall controller for the 5-stage RV32I core. It sits in the ID/EX boundary, directly upstream of the EX-stage forwarding unit, and covers what forwarding cannot: load-use dependences, taken-branch redirects and cache-miss freezes. It drives every pipeline-register load enable and the squash controls. It also remembers which cache has already answered during a freeze, and it keeps saturating performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 (rv32i_reg)  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5 (rv32i_reg)  destination of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- br_redirect  in  1  EX resolved a taken branch/jump this cycle
- imem_read, imem_resp  in  1  I-cache request / response
- dmem_read, dmem_write, dmem_resp  in  1  D-cache request / response
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  register enables
- bubble_id_ex  out  1  load NOP into ID/EX instead of ID contents
- flush_if_id  out  1  load NOP into IF/ID
- imem_gate, dmem_gate  out  1  AND-masks for imem_read / (dmem_read|dmem_write) toward the caches
- stall_cnt, lu_cnt, flush_cnt  out  CNT_W  perf counters

## Operation
- State registers: i_done, d_done (a response has already arrived during the current freeze), plus the three counters.
- d_req = dmem_read|dmem_write. i_wait = imem_read & ~imem_resp & ~i_done. d_wait = d_req & ~dmem_resp & ~d_done. mem_stall = i_wait|d_wait.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority is mem_stall > br_redirect > load_use > normal.
- mem_stall: all five load_* are 0; bubble and flush are 0; stall_cnt increments. i_done is set if imem_resp; d_done is set if dmem_resp.
- redirect: all load_* are 1, flush_if_id=1 and bubble_id_ex=1, so both wrong-path instructions are squashed. load_use is ignored. flush_cnt increments.
- load_use: load_pc=load_if_id=0, load_id_ex=load_ex_mem=load_mem_wb=1, bubble_id_ex=1. lu_cnt increments. Exactly one bubble is inserted; the loaded value then reaches EX via WB forwarding.
- normal: all load_* are 1; bubble and flush are 0.
- Flag clear: i_done and d_done clear in any cycle with load_mem_wb=1. Set takes effect only in stall cycles, so there is no set/clear conflict.
- Gating: imem_gate=~i_done and dmem_gate=~d_done. This stops a finished cache from re-issuing while the other side is still missing.
- Counters saturate at all-ones and never wrap.

## Timing
- All outputs are combinational from the inputs and the state registers, with zero-cycle latency. State updates on the posedge of clk.
- Reset is asynchronous. While rst_n=0: flags=0, counters=0, all load_*=0, bubble_id_ex=0, flush_if_id=0, imem_gate=dmem_gate=1.
- Reset deasserted mid-freeze: the flags are lost, and any outstanding request is re-issued ungated.
- Simultaneous responses (imem_resp and dmem_resp in the same cycle with no other wait): mem_stall=0 and the pipeline advances that cycle. Neither flag is set.
- A response arriving in the same cycle the other side is still waiting sets its flag. Release happens on the other side's response.
- br_redirect and load_use together, with no stall: redirect behaviour only. lu_cnt does not change.

## Structure
- rv32i_reg comes from the shared rv32i_types package. No new package types are needed.
- One sub-module: hzd_sat_counter (parameter CNT_W, with inc, clk and rst_n). It is instantiated three times.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> load_pc=0, load_if_id=0, bubble_id_ex=1, load_mem_wb=1, lu_cnt 0->1. The next cycle (no match) returns to all load_*=1.
- x0 / unused source: ex_rd=0 with a matching rs1, or a match with id_use_rs1=0 -> no bubble, lu_cnt unchanged.
- Split miss: imem and dmem both requested; imem_resp at cycle 2, dmem_resp at cycle 5 -> load_*=0 for cycles 0-4, imem_gate=0 for cycles 3-5, all load_*=1 at cycle 5, i_done clear at cycle 6, stall_cnt=5.
- Redirect plus load-use: br_redirect=1 with the load_use condition true and no miss -> flush_if_id=1, bubble_id_ex=1, load_pc=1, flush_cnt+1, lu_cnt+0.
- Redirect during a miss: br_redirect=1 with d_wait=1 -> everything frozen, flush=0. On dmem_resp -> flush_if_id=1 and load_pc=1 in the same cycle.
- Reset mid-freeze and saturation: drop rst_n during d_wait -> all load_*=0 and d_done=0 immediately. With CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/rv32i_types.sv
// +----------------------------------------------------------------------+
// | rv32i_types: shared RV32I core types                                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

  typedef logic [4:0] rv32i_reg;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/hzd_sat_counter.sv
// +----------------------------------------------------------------------+
// | hzd_sat_counter: event counter that sticks at all-ones               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hzd_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule : hzd_sat_counter

`default_nettype wire

// File: rtl/hazard_unit.sv
// +----------------------------------------------------------------------+
// | hazard_unit: load-use, redirect and cache-miss stall controller      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_unit
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  rv32i_reg         ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_redirect,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             imem_gate,
  output logic             dmem_gate,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic r_i_done;
  logic r_d_done;

  logic w_d_req;
  logic w_i_wait;
  logic w_d_wait;
  logic w_mem_stall;
  logic w_load_use;
  logic w_stall_inc;
  logic w_lu_inc;
  logic w_flush_inc;

  assign w_d_req     = dmem_read | dmem_write;
  assign w_i_wait    = imem_read & ~imem_resp & ~r_i_done;
  assign w_d_wait    = w_d_req & ~dmem_resp & ~r_d_done;
  assign w_mem_stall = w_i_wait | w_d_wait;

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    w_stall_inc  = 1'b0;
    w_lu_inc     = 1'b0;
    w_flush_inc  = 1'b0;
    if (!rst_n) begin
      // Everything stays frozen while reset is held.
    end else if (w_mem_stall) begin
      w_stall_inc = 1'b1;
    end else if (br_redirect) begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      bubble_id_ex = 1'b1;
      flush_if_id  = 1'b1;
      w_flush_inc  = 1'b1;
    end else if (w_load_use) begin
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
      bubble_id_ex = 1'b1;
      w_lu_inc     = 1'b1;
    end else begin
      load_pc      = 1'b1;
      load_if_id   = 1'b1;
      load_id_ex   = 1'b1;
      load_ex_mem  = 1'b1;
      load_mem_wb  = 1'b1;
    end
  end

  // Flags only set while frozen and only clear when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else if (w_mem_stall) begin
      if (imem_resp) r_i_done <= 1'b1;
      if (dmem_resp) r_d_done <= 1'b1;
    end else if (load_mem_wb) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end
  end

  assign imem_gate = ~r_i_done;
  assign dmem_gate = ~r_d_done;

  hzd_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  hzd_sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_lu_inc),
    .count (lu_cnt)
  );

  hzd_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule : hazard_unit

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// +----------------------------------------------------------------------+
// | tb_hazard_unit: directed bench with a mode-table reference model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, br_redirect;
  logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;

  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        bubble_id_ex, flush_if_id, imem_gate, dmem_gate;
  logic [31:0] stall_cnt, lu_cnt, flush_cnt;

  logic        load_pc_4, load_if_id_4, load_id_ex_4, load_ex_mem_4, load_mem_wb_4;
  logic        bubble_id_ex_4, flush_if_id_4, imem_gate_4, dmem_gate_4;
  logic [3:0]  stall_cnt_4, lu_cnt_4, flush_cnt_4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .br_redirect(br_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .imem_gate(imem_gate), .dmem_gate(dmem_gate),
    .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .br_redirect(br_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_pc(load_pc_4), .load_if_id(load_if_id_4), .load_id_ex(load_id_ex_4),
    .load_ex_mem(load_ex_mem_4), .load_mem_wb(load_mem_wb_4),
    .bubble_id_ex(bubble_id_ex_4), .flush_if_id(flush_if_id_4),
    .imem_gate(imem_gate_4), .dmem_gate(dmem_gate_4),
    .stall_cnt(stall_cnt_4), .lu_cnt(lu_cnt_4), .flush_cnt(flush_cnt_4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline mode decides the control vector from a table.
  localparam int MD_RESET = 0, MD_FREEZE = 1, MD_REDIR = 2, MD_LU = 3, MD_RUN = 4;
  logic   m_i_done = 1'b0, m_d_done = 1'b0;
  longint m_stall = 0, m_lu = 0, m_flush = 0;

  function automatic int cur_mode();
    bit iw, dw, hit1, hit2;
    if (rst_n !== 1'b1) return MD_RESET;
    iw = imem_read && !imem_resp && !m_i_done;
    dw = (dmem_read || dmem_write) && !dmem_resp && !m_d_done;
    if (iw || dw) return MD_FREEZE;
    if (br_redirect) return MD_REDIR;
    hit1 = id_use_rs1 && (id_rs1 == ex_rd);
    hit2 = id_use_rs2 && (id_rs2 == ex_rd);
    if (ex_mem_read && ex_rd != 0 && (hit1 || hit2)) return MD_LU;
    return MD_RUN;
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush}
  function automatic logic [6:0] ctl_of(input int md);
    case (md)
      MD_REDIR: return 7'b1111111;
      MD_LU:    return 7'b0011110;
      MD_RUN:   return 7'b1111100;
      default:  return 7'b0000000;
    endcase
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int md;
    if (!rst_n) begin
      m_i_done = 1'b0; m_d_done = 1'b0;
      m_stall = 0; m_lu = 0; m_flush = 0;
    end else begin
      md = cur_mode();
      if (md == MD_FREEZE) begin
        m_stall++;
        if (imem_resp) m_i_done = 1'b1;
        if (dmem_resp) m_d_done = 1'b1;
      end else begin
        if (md == MD_REDIR) m_flush++;
        if (md == MD_LU) m_lu++;
        m_i_done = 1'b0;
        m_d_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] e;
    e = ctl_of(cur_mode());
    chk("m_ctl32", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    bubble_id_ex, flush_if_id}, e);
    chk("m_ctl4", {load_pc_4, load_if_id_4, load_id_ex_4, load_ex_mem_4, load_mem_wb_4,
                   bubble_id_ex_4, flush_if_id_4}, e);
    chk("m_gates", {imem_gate, dmem_gate, imem_gate_4, dmem_gate_4},
        {!m_i_done, !m_d_done, !m_i_done, !m_d_done});
    chk("m_stall32", stall_cnt, sat(m_stall, 32));
    chk("m_lu32",    lu_cnt,    sat(m_lu, 32));
    chk("m_flush32", flush_cnt, sat(m_flush, 32));
    chk("m_stall4",  stall_cnt_4, sat(m_stall, 4));
    chk("m_lu4",     lu_cnt_4,    sat(m_lu, 4));
    chk("m_flush4",  flush_cnt_4, sat(m_flush, 4));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; br_redirect = 0;
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    set_lu(); imem_read = 1; br_redirect = 1;
    @(negedge clk);
    chk("rst_load_pc", load_pc, 0);
    chk("rst_load_mem_wb", load_mem_wb, 0);
    chk("rst_flush_bubble", {flush_if_id, bubble_id_ex}, 2'b00);
    chk("rst_gates", {imem_gate, dmem_gate}, 2'b11);
    chk("rst_stall_cnt", stall_cnt, 0);
    nxt();
    clr();
    rst_n = 1'b1;

    // Load-use: one bubble, then normal flow.
    set_lu();
    @(negedge clk);
    chk("lu_load_pc", load_pc, 0);
    chk("lu_load_if_id", load_if_id, 0);
    chk("lu_bubble", bubble_id_ex, 1);
    chk("lu_load_mem_wb", load_mem_wb, 1);
    chk("lu_cnt_before", lu_cnt, 0);
    nxt();
    clr();
    @(negedge clk);
    chk("lu_cnt_after", lu_cnt, 1);
    chk("lu_release", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 5'h1f);
    nxt();

    // x0 destination and unused source never stall.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    chk("x0_no_bubble", {bubble_id_ex, load_pc}, 2'b01);
    nxt();
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 3; id_use_rs2 = 1;
    @(negedge clk);
    chk("unused_no_bubble", {bubble_id_ex, load_pc}, 2'b01);
    nxt();
    clr();
    @(negedge clk);
    chk("x0_lu_cnt", lu_cnt, 1);
    nxt();

    // Redirect overrides load-use.
    set_lu(); br_redirect = 1;
    @(negedge clk);
    chk("redir_lu_ctl", {flush_if_id, bubble_id_ex, load_pc}, 3'b111);
    nxt();
    clr();
    @(negedge clk);
    chk("redir_flush_cnt", flush_cnt, 1);
    chk("redir_lu_cnt", lu_cnt, 1);
    nxt();

    // Redirect held behind a D-miss, released on response.
    dmem_read = 1; br_redirect = 1;
    @(negedge clk);
    chk("redir_miss_frozen", {load_pc, flush_if_id}, 2'b00);
    nxt();
    dmem_resp = 1;
    @(negedge clk);
    chk("redir_miss_release", {load_pc, flush_if_id}, 2'b11);
    nxt();
    clr();

    // Simultaneous responses: no stall, no flag.
    imem_read = 1; imem_resp = 1; dmem_read = 1; dmem_resp = 1;
    @(negedge clk);
    chk("simul_advance", load_mem_wb, 1);
    nxt();
    clr();
    @(negedge clk);
    chk("simul_gates", {imem_gate, dmem_gate}, 2'b11);
    nxt();

    // Split miss from a clean reset.
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      imem_read = (c <= 5); dmem_read = (c <= 5);
      imem_resp = (c == 2); dmem_resp = (c == 5);
      @(negedge clk);
      if (c <= 4) chk($sformatf("split_frozen_c%0d", c), load_pc, 0);
      if (c >= 3 && c <= 5) chk($sformatf("split_igate_c%0d", c), imem_gate, 0);
      if (c == 5) chk("split_release", {load_pc, load_mem_wb}, 2'b11);
      if (c == 6) begin
        chk("split_iclear", imem_gate, 1);
        chk("split_stall_cnt", stall_cnt, 5);
      end
      nxt();
    end
    clr();

    // Reset asserted mid-freeze drops the flags immediately.
    imem_read = 1; dmem_read = 1; dmem_resp = 1;
    nxt();
    dmem_resp = 0;
    @(negedge clk);
    chk("mf_dgate_set", dmem_gate, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mf_rst_loads", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 5'h00);
    chk("mf_rst_dgate", dmem_gate, 1);
    chk("mf_rst_stall", stall_cnt, 0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mf_reissue", {dmem_gate, load_pc}, 2'b10);
    nxt();

    // Saturation: 4-bit counter sticks at 15, 32-bit keeps counting.
    dmem_read = 0;
    repeat (20) nxt();
    @(negedge clk);
    chk("sat_stall4", stall_cnt_4, 15);
    chk("sat_stall32", stall_cnt, 21);
    nxt();
    clr();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_unit

`default_nettype wire
